// File: rtl/wb_cpu_bus_if.sv
// Wishbone master bridge for one pipeline memory port (IF or MEM).
// Ports: clk/rst, stall_i/flush_i from the controller, cpu_* request
// side, cpu_data_o/stallreq/bus_err_o back to the pipeline, and the
// classic Wishbone master signals wb_*.
module wb_cpu_bus_if #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] BUS_ERR_DATA   = 32'h00000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall_i,
    input  logic        flush_i,
    input  logic        cpu_ce_i,
    input  logic [31:0] cpu_data_i,
    input  logic [31:0] cpu_addr_i,
    input  logic        cpu_we_i,
    input  logic [3:0]  cpu_sel_i,
    output logic [31:0] cpu_data_o,
    output logic        stallreq,
    output logic        bus_err_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic [3:0]  wb_sel_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        WAIT_FOR_STALL
    } state_e;

    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_e      state_q, state_d;
    logic        cyc_q, cyc_d;
    logic        we_q, we_d;
    logic [31:0] adr_q, adr_d;
    logic [31:0] dat_q, dat_d;
    logic [3:0]  sel_q, sel_d;
    logic [31:0] rd_buf_q, rd_buf_d;
    logic [15:0] cnt_q, cnt_d;
    logic        err_q, err_d;
    logic        rel;
    logic        held;

    // Another pipeline source is stalling; keep the result until it clears.
    assign held = |stall_i;

    always_comb begin
        state_d    = state_q;
        cyc_d      = cyc_q;
        we_d       = we_q;
        adr_d      = adr_q;
        dat_d      = dat_q;
        sel_d      = sel_q;
        rd_buf_d   = rd_buf_q;
        cnt_d      = cnt_q;
        err_d      = 1'b0;
        rel        = 1'b0;
        stallreq   = 1'b0;
        cpu_data_o = 32'h0;
        unique case (state_q)
            IDLE: begin
                stallreq = cpu_ce_i & ~flush_i;
                if (cpu_ce_i && !flush_i) begin
                    cyc_d   = 1'b1;
                    we_d    = cpu_we_i;
                    adr_d   = cpu_addr_i;
                    dat_d   = cpu_data_i;
                    sel_d   = cpu_sel_i;
                    cnt_d   = 16'h0;
                    state_d = BUSY;
                end else begin
                    rel = 1'b1;
                end
            end
            BUSY: begin
                if (flush_i) begin
                    // Abort wins over a same-cycle ack.
                    rel      = 1'b1;
                    rd_buf_d = 32'h0;
                    state_d  = IDLE;
                end else if (wb_ack_i) begin
                    rel = 1'b1;
                    if (!we_q) begin
                        rd_buf_d   = wb_dat_i;
                        cpu_data_o = wb_dat_i;
                    end
                    state_d = held ? WAIT_FOR_STALL : IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    rel        = 1'b1;
                    rd_buf_d   = BUS_ERR_DATA;
                    cpu_data_o = BUS_ERR_DATA;
                    err_d      = 1'b1;
                    state_d    = held ? WAIT_FOR_STALL : IDLE;
                end else begin
                    if (cnt_q != 16'hFFFF) begin
                        cnt_d = cnt_q + 16'h1;
                    end
                    stallreq = 1'b1;
                end
            end
            WAIT_FOR_STALL: begin
                cpu_data_o = rd_buf_q;
                if (flush_i) begin
                    rd_buf_d = 32'h0;
                    state_d  = IDLE;
                end else if (!held) begin
                    state_d = IDLE;
                end
            end
            default: begin
                rel     = 1'b1;
                state_d = IDLE;
            end
        endcase
        if (rel) begin
            cyc_d = 1'b0;
            we_d  = 1'b0;
            adr_d = 32'h0;
            dat_d = 32'h0;
            sel_d = 4'h0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cyc_q    <= 1'b0;
            we_q     <= 1'b0;
            adr_q    <= 32'h0;
            dat_q    <= 32'h0;
            sel_q    <= 4'h0;
            rd_buf_q <= 32'h0;
            cnt_q    <= 16'h0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cyc_q    <= cyc_d;
            we_q     <= we_d;
            adr_q    <= adr_d;
            dat_q    <= dat_d;
            sel_q    <= sel_d;
            rd_buf_q <= rd_buf_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
        end
    end

    assign wb_cyc_o  = cyc_q;
    assign wb_stb_o  = cyc_q;
    assign wb_we_o   = we_q;
    assign wb_adr_o  = adr_q;
    assign wb_dat_o  = dat_q;
    assign wb_sel_o  = sel_q;
    assign bus_err_o = err_q;

endmodule

// File: tb/tb_wb_cpu_bus_if.sv
// Self-checking bench for wb_cpu_bus_if.
// Directed scenarios followed by randomized transactions.
module tb_wb_cpu_bus_if;

    localparam int          T   = 4;
    localparam logic [31:0] ERR = 32'hBADC0DE5;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall_i;
    logic        flush_i;
    logic        cpu_ce_i;
    logic [31:0] cpu_data_i;
    logic [31:0] cpu_addr_i;
    logic        cpu_we_i;
    logic [3:0]  cpu_sel_i;
    logic [31:0] cpu_data_o;
    logic        stallreq;
    logic        bus_err_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_we_o;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic [31:0] wb_dat_i;
    logic        wb_ack_i;

    wb_cpu_bus_if #(
        .TIMEOUT_CYCLES(T),
        .BUS_ERR_DATA  (ERR)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .stall_i   (stall_i),
        .flush_i   (flush_i),
        .cpu_ce_i  (cpu_ce_i),
        .cpu_data_i(cpu_data_i),
        .cpu_addr_i(cpu_addr_i),
        .cpu_we_i  (cpu_we_i),
        .cpu_sel_i (cpu_sel_i),
        .cpu_data_o(cpu_data_o),
        .stallreq  (stallreq),
        .bus_err_o (bus_err_o),
        .wb_cyc_o  (wb_cyc_o),
        .wb_stb_o  (wb_stb_o),
        .wb_we_o   (wb_we_o),
        .wb_adr_o  (wb_adr_o),
        .wb_dat_o  (wb_dat_o),
        .wb_sel_o  (wb_sel_o),
        .wb_dat_i  (wb_dat_i),
        .wb_ack_i  (wb_ack_i)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] rdbuf_m = 32'h0;
    bit          err_next = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle, then check the error pulse.
    task automatic settle();
        #1;
        chk("bus_err", 32'(bus_err_o), 32'(err_next));
        err_next = 1'b0;
    endtask

    task automatic chk_bus(input string tag, input logic c);
        chk({tag, "_cyc"}, 32'(wb_cyc_o), 32'(c));
        chk({tag, "_stb"}, 32'(wb_stb_o), 32'(c));
    endtask

    task automatic idle_cycle();
        cpu_ce_i = 1'b0;
        flush_i  = 1'b0;
        stall_i  = 6'h0;
        wb_ack_i = 1'b0;
        settle();
        chk_bus("idle", 1'b0);
        chk("idle_stallreq", 32'(stallreq), 32'h0);
        chk("idle_data", cpu_data_o, 32'h0);
        next_cycle();
    endtask

    // One transaction from its IDLE cycle onward.
    // dly: BUSY cycle index carrying ack (<0 or >=T means never).
    // hold: cycles spent in WAIT_FOR_STALL; fl flushes the last one.
    task automatic do_txn(input logic [31:0] a, input logic [31:0] d,
                          input logic w, input logic [3:0] s,
                          input int dly, input logic [31:0] rd,
                          input int hold, input bit fl);
        bit          to;
        logic [5:0]  nz;
        to = (dly < 0) || (dly >= T);
        cpu_ce_i   = 1'b1;
        flush_i    = 1'b0;
        stall_i    = 6'h0;
        wb_ack_i   = 1'b0;
        cpu_addr_i = a;
        cpu_data_i = d;
        cpu_we_i   = w;
        cpu_sel_i  = s;
        settle();
        chk("req_stallreq", 32'(stallreq), 32'h1);
        chk_bus("req", 1'b0);
        chk("req_data", cpu_data_o, 32'h0);
        for (int k = 0; k < T; k++) begin
            next_cycle();
            cpu_addr_i = $urandom;
            cpu_data_i = $urandom;
            cpu_we_i   = 1'($urandom);
            cpu_sel_i  = 4'($urandom);
            wb_dat_i   = $urandom;
            wb_ack_i   = 1'b0;
            stall_i    = 6'h0;
            if (k == dly) begin
                wb_ack_i = 1'b1;
                wb_dat_i = rd;
            end
            if (k == dly || (to && k == T - 1)) begin
                nz = 6'($urandom_range(1, 63));
                stall_i = (hold > 0) ? nz : 6'h0;
            end
            settle();
            chk_bus("busy", 1'b1);
            chk("busy_adr", wb_adr_o, a);
            chk("busy_dat", wb_dat_o, d);
            chk("busy_we", 32'(wb_we_o), 32'(w));
            chk("busy_sel", 32'(wb_sel_o), 32'(s));
            if (k == dly) begin
                chk("ack_stallreq", 32'(stallreq), 32'h0);
                chk("ack_data", cpu_data_o, w ? 32'h0 : rd);
                break;
            end
            if (to && k == T - 1) begin
                chk("to_stallreq", 32'(stallreq), 32'h0);
                chk("to_data", cpu_data_o, ERR);
                break;
            end
            chk("wait_ack_stallreq", 32'(stallreq), 32'h1);
            chk("wait_ack_data", cpu_data_o, 32'h0);
        end
        rdbuf_m  = to ? ERR : (w ? rdbuf_m : rd);
        err_next = to;
        for (int h = 0; h < hold; h++) begin
            next_cycle();
            wb_ack_i = 1'b0;
            cpu_ce_i = 1'b1;
            nz = 6'($urandom_range(1, 63));
            stall_i = (h < hold - 1 || fl) ? nz : 6'h0;
            flush_i = (fl && h == hold - 1);
            settle();
            chk_bus("hold", 1'b0);
            chk("hold_stallreq", 32'(stallreq), 32'h0);
            chk("hold_data", cpu_data_o, rdbuf_m);
        end
        if (fl && hold > 0) rdbuf_m = 32'h0;
        next_cycle();
        wb_ack_i = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        stall_i    = 6'h0;
        flush_i    = 1'b0;
        cpu_ce_i   = 1'b0;
        cpu_data_i = 32'h0;
        cpu_addr_i = 32'h0;
        cpu_we_i   = 1'b0;
        cpu_sel_i  = 4'h0;
        wb_dat_i   = 32'h0;
        wb_ack_i   = 1'b0;
        next_cycle();
        next_cycle();
        settle();
        chk_bus("rst", 1'b0);
        chk("rst_we", 32'(wb_we_o), 32'h0);
        chk("rst_adr", wb_adr_o, 32'h0);
        chk("rst_dat", wb_dat_o, 32'h0);
        chk("rst_sel", 32'(wb_sel_o), 32'h0);
        chk("rst_stallreq", 32'(stallreq), 32'h0);
        chk("rst_data", cpu_data_o, 32'h0);
        rst = 1'b0;
        next_cycle();
        idle_cycle();

        // Read acked on third BUSY cycle.
        do_txn(32'h100, 32'h0, 1'b0, 4'hF, 2, 32'hDEADBEEF, 0, 1'b0);
        idle_cycle();

        // Read acked under a held external stall.
        do_txn(32'h204, 32'h0, 1'b0, 4'hF, 1, 32'h12345678, 5, 1'b0);

        // Write flushed in second BUSY cycle together with ack.
        cpu_ce_i   = 1'b1;
        flush_i    = 1'b0;
        stall_i    = 6'h0;
        cpu_addr_i = 32'h300;
        cpu_data_i = 32'hA5A5A5A5;
        cpu_we_i   = 1'b1;
        cpu_sel_i  = 4'b0011;
        settle();
        chk("fl_req_stallreq", 32'(stallreq), 32'h1);
        next_cycle();
        settle();
        chk_bus("fl_busy0", 1'b1);
        chk("fl_busy0_stallreq", 32'(stallreq), 32'h1);
        next_cycle();
        flush_i  = 1'b1;
        wb_ack_i = 1'b1;
        wb_dat_i = 32'h55AA55AA;
        stall_i  = 6'b001111;
        settle();
        chk_bus("fl_busy1", 1'b1);
        chk("fl_we", 32'(wb_we_o), 32'h1);
        chk("fl_sel", 32'(wb_sel_o), 32'h3);
        chk("fl_dat", wb_dat_o, 32'hA5A5A5A5);
        chk("fl_stallreq", 32'(stallreq), 32'h0);
        chk("fl_data", cpu_data_o, 32'h0);
        rdbuf_m = 32'h0;
        next_cycle();
        wb_ack_i = 1'b0;
        settle();
        chk("fl_after_adr", wb_adr_o, 32'h0);
        chk("fl_after_sel", 32'(wb_sel_o), 32'h0);
        // Write leaves rd_buf alone, so the hold shows the cleared buffer.
        do_txn(32'h304, 32'h1, 1'b1, 4'hF, 0, 32'h0, 2, 1'b0);

        // Flush while waiting clears the buffer.
        do_txn(32'h400, 32'h0, 1'b0, 4'hF, 0, 32'hCAFEF00D, 2, 1'b1);
        do_txn(32'h404, 32'h2, 1'b1, 4'hF, 1, 32'h0, 2, 1'b0);

        // Timeout: no ack ever.
        do_txn(32'h500, 32'h0, 1'b0, 4'hF, -1, 32'h0, 2, 1'b0);
        idle_cycle();

        // Reset in the middle of BUSY.
        cpu_ce_i   = 1'b1;
        cpu_addr_i = 32'h600;
        cpu_we_i   = 1'b0;
        settle();
        next_cycle();
        settle();
        chk_bus("mid_busy", 1'b1);
        rst      = 1'b1;
        cpu_ce_i = 1'b0;
        next_cycle();
        rst = 1'b0;
        settle();
        chk_bus("mid_rst", 1'b0);
        chk("mid_rst_adr", wb_adr_o, 32'h0);
        chk("mid_rst_stallreq", 32'(stallreq), 32'h0);
        rdbuf_m = 32'h0;
        next_cycle();
        do_txn(32'h604, 32'h3, 1'b1, 4'hF, 0, 32'h0, 2, 1'b0);

        // Back-to-back reads with ce held high.
        do_txn(32'h700, 32'h0, 1'b0, 4'hF, 0, 32'h11111111, 0, 1'b0);
        do_txn(32'h704, 32'h0, 1'b0, 4'hF, 0, 32'h22222222, 0, 1'b0);
        do_txn(32'h708, 32'h0, 1'b0, 4'hF, 0, 32'h33333333, 0, 1'b0);

        // Randomized transactions.
        for (int n = 0; n < 60; n++) begin
            int  dly;
            int  hold;
            bit  fl;
            dly  = int'($urandom_range(0, 5)) - 1;
            hold = int'($urandom_range(0, 3));
            fl   = (hold > 0) && ($urandom_range(0, 3) == 0);
            do_txn($urandom, $urandom, 1'($urandom), 4'($urandom),
                   dly, $urandom, hold, fl);
            if ($urandom_range(0, 2) == 0) idle_cycle();
        end
        idle_cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
